// File: rtl/mult_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mult_rr_arbiter
//
// Purpose:
//   Shares one combinational unsigned array multiplier among NREQ requesters.
//   A round-robin arbiter accepts one operand pair at a time over a
//   valid/ready handshake. The operands are registered, multiplied over one
//   full cycle, and the product is returned on a shared response bus. The
//   response is tagged with the index of the requester that owns it.
//
// Ports:
//   clk        in   1            single rising-edge clock
//   rst        in   1            synchronous active-high reset
//   req_valid  in   NREQ         requester i presents operands
//   req_ready  out  NREQ         requester i's operands taken (one-hot/zero)
//   req_a      in   NREQ*WIDTH   packed multiplicands, i at [i*WIDTH +: WIDTH]
//   req_b      in   NREQ*WIDTH   packed multipliers, same packing
//   resp_valid out  1            product available
//   resp_ready in   1            consumer accepts product
//   resp_id    out  IDW          owner of the product
//   resp_prod  out  2*WIDTH      unsigned product a*b
//   busy       out  1            state is MUL or RESP
//   done_cnt   out  16           completed response handshakes (wrapping)
// ---------------------------------------------------------------------------

// Shift-and-add array multiplier: one partial-product row per multiplier bit.
// It is purely combinational and is given a full clock cycle to settle.
module array_multiplier #(
  parameter int WIDTH = 25
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] p
);

  logic [2*WIDTH-1:0] acc;

  // Accumulate the shifted multiplicand for every set bit of the multiplier
  always_comb begin
    acc = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (b[i]) begin
        acc = acc + ({{WIDTH{1'b0}}, a} << i);
      end
    end
  end

  assign p = acc;

endmodule

module mult_rr_arbiter #(
  parameter int WIDTH = 25,
  parameter int NREQ  = 4,
  parameter int IDW   = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*WIDTH-1:0]   req_a,
  input  logic [NREQ*WIDTH-1:0]   req_b,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [IDW-1:0]          resp_id,
  output logic [2*WIDTH-1:0]      resp_prod,
  output logic                    busy,
  output logic [15:0]             done_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    RESP
  } state_t;

  state_t             state;
  state_t             state_next;

  logic [IDW-1:0]     ptr;
  logic [IDW-1:0]     ptr_next;
  logic [IDW-1:0]     winner;
  logic               found;
  logic               grant;
  int                 idx;

  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic [IDW-1:0]     op_id;
  logic [2*WIDTH-1:0] product;

  // Round-robin search: the first valid requester at or above ptr, wrapping
  // modulo NREQ. The earliest hit wins, so later candidates are ignored.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        winner = IDW'(idx);
      end
    end
  end

  // A grant only happens in IDLE. It is suppressed while reset is high so
  // that no handshake can be observed by a requester during reset.
  assign grant = (state == IDLE) && !rst && found;

  // The pointer moves one past the winner so that the winner becomes the
  // lowest priority requester for the next search.
  assign ptr_next = (winner == IDW'(NREQ - 1)) ? '0 : winner + 1'b1;

  // Ready is a one-hot copy of the grant.
  always_comb begin
    req_ready = '0;
    if (grant) begin
      req_ready[winner] = 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. RESP always returns through IDLE, even with resp_ready
  // held high, so the next grant happens one cycle after the response is
  // taken.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (found) state_next = MUL;
      MUL:     state_next = RESP;
      RESP:    if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The multiplier sees only the operand registers, never req_a/req_b
  // directly, so its ripple path is register-to-register.
  array_multiplier #(
    .WIDTH (WIDTH)
  ) u_mult (
    .a (op_a),
    .b (op_b),
    .p (product)
  );

  // Datapath registers. Operands are captured on the grant, the product is
  // captured at the end of MUL, and it is held until the response handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr        <= '0;
      op_a       <= '0;
      op_b       <= '0;
      op_id      <= '0;
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_prod  <= '0;
      done_cnt   <= '0;
    end else begin
      if (grant) begin
        op_a  <= req_a[int'(winner)*WIDTH +: WIDTH];
        op_b  <= req_b[int'(winner)*WIDTH +: WIDTH];
        op_id <= winner;
        ptr   <= ptr_next;
      end
      if (state == MUL) begin
        resp_prod  <= product;
        resp_id    <= op_id;
        resp_valid <= 1'b1;
      end
      if (state == RESP && resp_ready) begin
        resp_valid <= 1'b0;
        done_cnt   <= done_cnt + 16'd1;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule
